// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the streaming MAC vector unit.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  // Accumulator width large enough that MAX_LEN beats of LANES full-scale products never overflow.
  function automatic int acc_w(int dw, int lanes, int max_len);
    return 2*dw + $clog2(lanes) + $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Balanced combinational reduction of LANES extended products, registered once (p2 stage).
module mac_adder_tree #(
  parameter int LANES = 4,
  parameter int ACC_W = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld,
  input  logic [LANES-1:0][ACC_W-1:0] in_data,
  output logic                        out_vld,
  output logic [ACC_W-1:0]            out_sum
);

  // Heap-ordered tree: leaves at [LANES +: LANES], root at node[1].
  logic [2*LANES-1:1][ACC_W-1:0] node;

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES+i] = in_data[i];
  end

  for (genvar n = 1; n < LANES; n++) begin : g_node
    assign node[n] = node[2*n] + node[2*n+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_sum <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) out_sum <= node[1];
    end
  end

endmodule

// File: rtl/mac_vector_unit.sv
// Streaming dot-product engine: p1 multipliers -> p2 adder tree -> accumulator, valid/ready out.
// Optional MAC_SAT_EN clamps the result to the OUT_W range instead of truncating.
module mac_vector_unit
  import mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 2*DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic                       signed_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_a,
  input  logic [LANES*DATA_W-1:0]    in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       busy
);

  localparam int ACC_W = acc_w(DATA_W, LANES, MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam int PW    = 2*DATA_W;

  state_e                      state_q, state_d;
  logic [LEN_W-1:0]            len_q, cnt_q;
  logic                        sgn_q;
  logic                        beat, last_beat, start_acc;
  logic [LANES-1:0][ACC_W-1:0] p1_d, p1_q;
  logic                        p1_vld, p2_vld;
  logic [ACC_W-1:0]            p2_sum, acc_q;

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt_q == len_q - LEN_W'(1));
  assign start_acc = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);

  // Operands are extended by one width first so a single multiplier serves both modes.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PW-1:0] ea, eb, prod;
    assign ea   = {{DATA_W{sgn_q & in_a[l*DATA_W+DATA_W-1]}}, in_a[l*DATA_W +: DATA_W]};
    assign eb   = {{DATA_W{sgn_q & in_b[l*DATA_W+DATA_W-1]}}, in_b[l*DATA_W +: DATA_W]};
    assign prod = ea * eb;
    assign p1_d[l] = {{(ACC_W-PW){sgn_q & prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld <= 1'b0;
      p1_q   <= '0;
    end else begin
      p1_vld <= beat;
      if (beat) p1_q <= p1_d;
    end
  end

  mac_adder_tree #(.LANES(LANES), .ACC_W(ACC_W)) u_tree (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (p1_vld),
    .in_data (p1_q),
    .out_vld (p2_vld),
    .out_sum (p2_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        len_q <= len;
        sgn_q <= signed_mode;
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        if (beat)   cnt_q <= cnt_q + LEN_W'(1);
        if (p2_vld) acc_q <= acc_q + p2_sum;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = (len == '0) ? OUT : RUN;
      RUN: begin
        in_ready = 1'b1;
        if (last_beat) state_d = DRAIN;
      end
      // Leave on the edge where the last tree sum lands in the accumulator.
      DRAIN: if (!p1_vld && p2_vld) state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    out_data = acc_q[OUT_W-1:0];
    if (sgn_q) begin
      if ($signed(acc_q) > $signed(SMAX))      out_data = SMAX[OUT_W-1:0];
      else if ($signed(acc_q) < $signed(SMIN)) out_data = SMIN[OUT_W-1:0];
    end else if (|acc_q[ACC_W-1:OUT_W]) begin
      out_data = '1;
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_q[ACC_W-1:OUT_W];
  assign out_data      = acc_q[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_mac_vector_unit.sv
// Directed scoreboard bench for mac_vector_unit: stimulus pushes expected results, a monitor pops on transfer.
module tb_mac_vector_unit;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int ML = 16;
  localparam int OW = 16;
  localparam int LW = $clog2(ML+1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LW-1:0]   len = '0;
  logic            signed_mode = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [L*DW-1:0] in_a = '0;
  logic [L*DW-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OW-1:0]   out_data;
  logic            busy;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] sb[$];

  mac_vector_unit #(.DATA_W(DW), .LANES(L), .MAX_LEN(ML), .OUT_W(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected no result", out_data);
      end else begin
        logic [OW-1:0] e;
        e = sb.pop_front();
        chk("result", {16'h0, out_data}, {16'h0, e});
      end
    end
  end

  task automatic run_vec(input int n, input logic sgn, input logic [L*DW-1:0] a,
                         input logic [L*DW-1:0] b, input logic [OW-1:0] exp, input bit gaps);
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(n); signed_mode = sgn;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk("len0_out_valid", {31'h0, out_valid}, 32'h1);
      chk("len0_in_ready", {31'h0, in_ready}, 32'h0);
      return;
    end
    in_a = a; in_b = b;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 4 == 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      if (i == 0) begin
        @(negedge clk);
        chk("run_in_ready", {31'h0, in_ready}, 32'h1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    // Last beat accepted at edge k: out_valid must rise exactly at k+2.
    @(negedge clk);
    chk("lat_k0", {31'h0, out_valid}, 32'h0);
    chk("drain_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk("lat_k1", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_k2", {31'h0, out_valid}, 32'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1 expected busy=0 within 50 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Unsigned, two back-to-back beats: (1+2+3+4)*2 per beat = 20, twice = 40.
    run_vec(2, 1'b0, 32'h04030201, 32'h02020202, 16'd40, 1'b0);
    wait_idle();

    // Unsigned, 16 full-scale beats with input gaps: 4161600 = 0x3F8040.
`ifdef MAC_SAT_EN
    run_vec(16, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 1'b1);
`else
    run_vec(16, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h8040, 1'b1);
`endif
    wait_idle();

    // Signed, -1*3 on four lanes = -12, held under backpressure for 10 cycles.
    out_ready = 1'b0;
    run_vec(1, 1'b1, 32'hFFFFFFFF, 32'h03030303, 16'hFFF4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_out_data", {16'h0, out_data}, 32'h0000FFF4);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
      if (i == 3) begin start = 1'b1; len = LW'(1); end
      if (i == 4) start = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_xfer_out_valid", {31'h0, out_valid}, 32'h0);
    chk("post_xfer_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("ignored_start_busy", {31'h0, busy}, 32'h0);

    // Zero-length vector returns 0 on the edge after start.
    run_vec(0, 1'b0, 32'h0, 32'h0, 16'h0000, 1'b0);
    wait_idle();

    // Abort an 8-beat vector after 3 beats with reset; nothing may be emitted for it.
    @(posedge clk); #1;
    start = 1'b1; len = LW'(8); signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_a = 32'h01010101; in_b = 32'h01010101; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_out_data", {16'h0, out_data}, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", {31'h0, out_valid}, 32'h0);
    end

    run_vec(1, 1'b0, 32'h01010101, 32'h01010101, 16'd4, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
